// File: rtl/triangle_raster_sequencer_if.sv
// Triangle descriptor input stream and covered-pixel output stream of triangle_raster_sequencer.
interface triangle_raster_sequencer_if;
  localparam int unsigned CW = 16;
  localparam int unsigned ZW = 8;

  logic          tri_valid;
  logic          tri_ready;
  logic [CW-1:0] tri_x [3];
  logic [CW-1:0] tri_y [3];
  logic          pix_valid;
  logic          pix_ready;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic [ZW-1:0] pix_z;

  modport master (
    output tri_valid, tri_x, tri_y, pix_ready,
    input  tri_ready, pix_valid, pix_x, pix_y, pix_z
  );

  modport slave (
    input  tri_valid, tri_x, tri_y, pix_ready,
    output tri_ready, pix_valid, pix_x, pix_y, pix_z
  );
endinterface

// File: rtl/triangle_raster_sequencer.sv
// Walks the screen-clamped bounding box of one triangle in raster order against triangle_generator
// and streams covered pixels; ZBUF_TEST_EN adds an early depth test against the framebuffer.
module triangle_raster_sequencer #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  localparam int unsigned CW = 16,
  localparam int unsigned ZW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  triangle_raster_sequencer_if.slave bus,
  output logic [CW-1:0] gen_x,
  output logic [CW-1:0] gen_y,
  input  logic          gen_inside,
  input  logic [ZW-1:0] gen_z,
  output logic          busy,
  output logic          tri_done
`ifdef ZBUF_TEST_EN
  ,
  output logic          zb_rd_en,
  output logic [CW-1:0] zb_rd_x,
  output logic [CW-1:0] zb_rd_y,
  input  logic [ZW-1:0] zb_rd_data
`endif
);

  localparam logic [CW-1:0] X_LAST = CW'(SCREEN_W - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BBOX, S_SCAN, S_EMIT, S_ZRD, S_ZCMP, S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] vx [3];
  logic [CW-1:0] vy [3];
  logic [CW-1:0] xmin, xmax, ymin, ymax;
  logic          tri_ready;

  logic [CW-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic          bb_empty;
  logic [CW-1:0] adv_x, adv_y;
  logic          adv_last;
  logic          adv_req;

  assign bus.tri_ready = tri_ready;

  function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bounding box of the captured vertices; only the max side is clamped, an off-screen min means empty.
  always_comb begin
    bb_xmin  = min3(vx[0], vx[1], vx[2]);
    bb_ymin  = min3(vy[0], vy[1], vy[2]);
    bb_xmax  = max3(vx[0], vx[1], vx[2]);
    bb_ymax  = max3(vy[0], vy[1], vy[2]);
    if (bb_xmax > X_LAST) bb_xmax = X_LAST;
    if (bb_ymax > Y_LAST) bb_ymax = Y_LAST;
    bb_empty = (bb_xmin > X_LAST) || (bb_ymin > Y_LAST);
  end

  // Next raster position; never computed past the clamped max because adv_last ends the scan first.
  always_comb begin
    adv_last = (gen_x == xmax) && (gen_y == ymax);
    if (gen_x == xmax) begin
      adv_x = xmin;
      adv_y = gen_y + CW'(1);
    end else begin
      adv_x = gen_x + CW'(1);
      adv_y = gen_y;
    end
  end

  always_comb begin
    adv_req = 1'b0;
    case (state)
      S_SCAN:  adv_req = !gen_inside;
      S_EMIT:  adv_req = bus.pix_ready;
`ifdef ZBUF_TEST_EN
      S_ZCMP:  adv_req = !(gen_z < zb_rd_data);
`endif
      default: adv_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      tri_ready     <= 1'b0;
      busy          <= 1'b0;
      tri_done      <= 1'b0;
      gen_x         <= '0;
      gen_y         <= '0;
      bus.pix_valid <= 1'b0;
      bus.pix_x     <= '0;
      bus.pix_y     <= '0;
      bus.pix_z     <= '0;
      vx            <= '{default: '0};
      vy            <= '{default: '0};
      xmin          <= '0;
      xmax          <= '0;
      ymin          <= '0;
      ymax          <= '0;
`ifdef ZBUF_TEST_EN
      zb_rd_en      <= 1'b0;
      zb_rd_x       <= '0;
      zb_rd_y       <= '0;
`endif
    end else begin
      tri_done <= 1'b0;
`ifdef ZBUF_TEST_EN
      zb_rd_en <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          tri_ready <= 1'b1;
          if (bus.tri_valid && tri_ready) begin
            vx        <= bus.tri_x;
            vy        <= bus.tri_y;
            tri_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_BBOX;
          end
        end
        S_BBOX: begin
          xmin <= bb_xmin;
          xmax <= bb_xmax;
          ymin <= bb_ymin;
          ymax <= bb_ymax;
          if (bb_empty) begin
            tri_done <= 1'b1;
            busy     <= 1'b0;
            state    <= S_DONE;
          end else begin
            gen_x <= bb_xmin;
            gen_y <= bb_ymin;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (gen_inside) begin
`ifdef ZBUF_TEST_EN
            zb_rd_en <= 1'b1;
            zb_rd_x  <= gen_x;
            zb_rd_y  <= gen_y;
            state    <= S_ZRD;
`else
            bus.pix_valid <= 1'b1;
            bus.pix_x     <= gen_x;
            bus.pix_y     <= gen_y;
            bus.pix_z     <= gen_z;
            state         <= S_EMIT;
`endif
          end
        end
`ifdef ZBUF_TEST_EN
        S_ZRD: state <= S_ZCMP;
        // Read data arrives here; gen_x/gen_y are still held so gen_z is still for this pixel.
        S_ZCMP: begin
          if (gen_z < zb_rd_data) begin
            bus.pix_valid <= 1'b1;
            bus.pix_x     <= gen_x;
            bus.pix_y     <= gen_y;
            bus.pix_z     <= gen_z;
            state         <= S_EMIT;
          end
        end
`endif
        S_EMIT: begin
          if (bus.pix_ready) bus.pix_valid <= 1'b0;
        end
        S_DONE: begin
          tri_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (adv_req) begin
        if (adv_last) begin
          tri_done <= 1'b1;
          busy     <= 1'b0;
          state    <= S_DONE;
        end else begin
          gen_x <= adv_x;
          gen_y <= adv_y;
          state <= S_SCAN;
        end
      end
    end
  end

endmodule

// File: tb/tb_triangle_raster_sequencer.sv
// Randomised bench for triangle_raster_sequencer with a raster-scan reference model and literal anchors.
module tb_triangle_raster_sequencer;
  localparam int SW = 640;
  localparam int SH = 480;
`ifdef ZBUF_TEST_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  typedef struct { int x; int y; int z; } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] gen_x, gen_y;
  logic        gen_inside;
  logic [7:0]  gen_z;
  logic        busy, tri_done;
`ifdef ZBUF_TEST_EN
  logic        zb_rd_en;
  logic [15:0] zb_rd_x, zb_rd_y;
  logic [7:0]  zb_rd_data = 8'd2;
`endif

  int          tests = 0;
  int          fails = 0;
  int          mode = 0;
  int unsigned seed = 0;
  bit          chk_en = 1'b0;
  bit          bp_mode = 1'b0;
  bit          rnd_ready = 1'b0;
  int          stall_cnt = 0;
  int          n_out = 0;
  pix_t        exp_q[$];
  pix_t        got_q[$];
  pix_t        cmp_e;
  int          exp_cycles;
  bit          exp_empty;
  int          exp_x0, exp_y0;
  bit          prev_stall = 1'b0;
  logic [15:0] hold_x, hold_y;
  logic [7:0]  hold_z;

  triangle_raster_sequencer_if bus();

  triangle_raster_sequencer #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .gen_x      (gen_x),
    .gen_y      (gen_y),
    .gen_inside (gen_inside),
    .gen_z      (gen_z),
    .busy       (busy),
    .tri_done   (tri_done)
`ifdef ZBUF_TEST_EN
    ,
    .zb_rd_en   (zb_rd_en),
    .zb_rd_x    (zb_rd_x),
    .zb_rd_y    (zb_rd_y),
    .zb_rd_data (zb_rd_data)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for triangle_generator: mode 0 is the x+y<=3 wedge, mode 1 a seeded pattern.
  function automatic logic f_in(input logic [15:0] x, input logic [15:0] y, input int m,
                                input int unsigned s);
    if (m == 0) return (32'(x) + 32'(y)) <= 32'd3;
    return ((32'(x) * 32'd3 + 32'(y) * 32'd5 + s) % 32'd3) != 32'd0;
  endfunction

  function automatic logic [7:0] f_z(input logic [15:0] x, input logic [15:0] y, input int m,
                                     input int unsigned s);
    if (m == 0) return 8'(32'(x) + 32'(y));
    return 8'(32'(x ^ y) + s);
  endfunction

  always_comb begin
    gen_inside = f_in(gen_x, gen_y, mode, seed);
    gen_z      = f_z(gen_x, gen_y, mode, seed);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference: clamp the box, scan rows then columns, keep what the generator (and depth test) passes.
  task automatic build_model(input int tx[3], input int ty[3]);
    int x0, x1, y0, y1, z;
    x0 = tx[0]; x1 = tx[0]; y0 = ty[0]; y1 = ty[0];
    for (int i = 1; i < 3; i++) begin
      if (tx[i] < x0) x0 = tx[i];
      if (tx[i] > x1) x1 = tx[i];
      if (ty[i] < y0) y0 = ty[i];
      if (ty[i] > y1) y1 = ty[i];
    end
    if (x1 > SW - 1) x1 = SW - 1;
    if (y1 > SH - 1) y1 = SH - 1;
    exp_q.delete();
    exp_cycles = 2;
    exp_empty  = (x0 > SW - 1) || (y0 > SH - 1);
    exp_x0 = x0; exp_y0 = y0;
    if (!exp_empty) begin
      for (int y = y0; y <= y1; y++) begin
        for (int x = x0; x <= x1; x++) begin
          exp_cycles++;
          if (f_in(16'(x), 16'(y), mode, seed)) begin
            z = int'(f_z(16'(x), 16'(y), mode, seed));
            if (ZB) exp_cycles += 2;
            if (!ZB || z < 2) begin
              exp_q.push_back('{x, y, z});
              exp_cycles++;
            end
          end
        end
      end
    end
  endtask

  // Downstream ready: always, randomly, or a 5-cycle stall on the second pixel.
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      if (bus.pix_valid && n_out == 1 && stall_cnt < 5) begin
        bus.pix_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.pix_ready = 1'b1;
      end
    end else if (rnd_ready) begin
      bus.pix_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.pix_ready = 1'b1;
    end
  end

  // Output monitor: every handshake against the model, stability under stall.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (prev_stall)
        chk("pix_hold", {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_z}, {1'b1, hold_x, hold_y, hold_z});
      if (bp_mode && bus.pix_valid && !bus.pix_ready)
        chk("bp_pixel", {bus.pix_x, bus.pix_y, bus.pix_z}, {16'd1, 16'd0, 8'd1});
      if (bus.pix_valid && bus.pix_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_pixel: got (%0d,%0d,%0d) expected none", bus.pix_x, bus.pix_y, bus.pix_z);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("pix", {bus.pix_x, bus.pix_y, bus.pix_z}, {16'(cmp_e.x), 16'(cmp_e.y), 8'(cmp_e.z)});
        end
        cmp_e.x = int'(bus.pix_x); cmp_e.y = int'(bus.pix_y); cmp_e.z = int'(bus.pix_z);
        got_q.push_back(cmp_e);
        n_out++;
      end
      if (tri_done) chk("missing_pixels", 64'(exp_q.size()), 64'd0);
`ifdef ZBUF_TEST_EN
      if (zb_rd_en) chk("zb_addr", {zb_rd_x, zb_rd_y}, {gen_x, gen_y});
`endif
      prev_stall = bus.pix_valid && !bus.pix_ready;
      hold_x = bus.pix_x; hold_y = bus.pix_y; hold_z = bus.pix_z;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_ctl"}, {bus.tri_ready, busy, tri_done, bus.pix_valid, bus.pix_z}, 64'd0);
    chk({nm, "_pos"}, {gen_x, gen_y, bus.pix_x, bus.pix_y}, 64'd0);
`ifdef ZBUF_TEST_EN
    chk({nm, "_zb"}, {zb_rd_en, zb_rd_x, zb_rd_y}, 64'd0);
`endif
  endtask

  task automatic start_tri(input int tx[3], input int ty[3]);
    int n;
    build_model(tx, ty);
    got_q.delete();
    n_out = 0; stall_cnt = 0; chk_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bus.tri_x[i] = 16'(tx[i]);
      bus.tri_y[i] = 16'(ty[i]);
    end
    bus.tri_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.tri_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 64'(bus.tri_ready), 64'd1);
    @(posedge clk); #1;
    bus.tri_valid = 1'b0;
  endtask

  task automatic finish_tri(input string nm, input bit chk_time, input int extra, input bit poke,
                            output int n);
    bit done;
    int limit;
    done  = 1'b0;
    limit = 20 * exp_cycles + 100;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
      if (chk_time && n == 2 && !exp_empty)
        chk({nm, "_first_gen"}, {gen_x, gen_y}, {16'(exp_x0), 16'(exp_y0)});
      if (poke && n == 4) begin
        chk({nm, "_ready_while_busy"}, 64'(bus.tri_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
          bus.tri_x[i] = 16'd200;
          bus.tri_y[i] = 16'd200;
        end
        bus.tri_valid = 1'b1;
      end
      if (poke && n == 6) bus.tri_valid = 1'b0;
      if (tri_done) done = 1'b1;
    end
    chk({nm, "_done_seen"}, 64'(done), 64'd1);
    if (done) begin
      if (chk_time) chk({nm, "_latency"}, 64'(n), 64'(exp_cycles + extra));
      chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
      @(negedge clk);
      chk({nm, "_done_pulse"}, {tri_done, bus.tri_ready}, {1'b0, 1'b1});
    end
  endtask

  initial begin
    int tx[3], ty[3];
    int n, bx, by, maxx, maxy;
    int lit_x[$], lit_y[$];

    bus.tri_valid = 1'b0;
    bus.pix_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.tri_x[i] = '0;
      bus.tri_y[i] = '0;
    end

    // Reset and release
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready", {bus.tri_ready, busy}, {1'b1, 1'b0});

    // Coverage wedge, literal result
    mode = 0;
    tx = '{0, 3, 0}; ty = '{0, 0, 3};
    start_tri(tx, ty);
    finish_tri("cov", 1'b1, 0, 1'b0, n);
    chk("cov_cycles", 64'(n), ZB ? 64'd41 : 64'd28);
    if (ZB) begin
      lit_x = '{0, 1, 0};
      lit_y = '{0, 0, 1};
    end else begin
      lit_x = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
      lit_y = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    end
    chk("cov_count", 64'(got_q.size()), 64'(lit_x.size()));
    for (int i = 0; i < lit_x.size() && i < got_q.size(); i++)
      chk($sformatf("cov_pix%0d", i), {16'(got_q[i].x), 16'(got_q[i].y), 8'(got_q[i].z)},
          {16'(lit_x[i]), 16'(lit_y[i]), 8'(lit_x[i] + lit_y[i])});

    // Backpressure on the second pixel, plus a descriptor offered while busy
    bp_mode = 1'b1;
    start_tri(tx, ty);
    finish_tri("bp", 1'b1, 5, 1'b1, n);
    bp_mode = 1'b0;
    chk("bp_count", 64'(got_q.size()), ZB ? 64'd3 : 64'd10);

    // Fully off-screen
    mode = 1; seed = 32'd7;
    tx = '{640, 700, 650}; ty = '{0, 5, 9};
    start_tri(tx, ty);
    finish_tri("offscreen", 1'b1, 0, 1'b0, n);
    chk("offscreen_cycles", 64'(n), 64'd2);
    chk("offscreen_pixels", 64'(got_q.size()), 64'd0);

    // Clamp at the right/bottom edge
    seed = 32'd1;
    tx = '{636, 700, 637}; ty = '{476, 478, 500};
    start_tri(tx, ty);
    finish_tri("clamp", 1'b1, 0, 1'b0, n);
    maxx = 0; maxy = 0;
    foreach (got_q[i]) begin
      if (got_q[i].x > maxx) maxx = got_q[i].x;
      if (got_q[i].y > maxy) maxy = got_q[i].y;
    end
    chk("clamp_max", {32'(maxx <= 639), 32'(maxy <= 479)}, {32'd1, 32'd1});

    // Single-pixel box
    mode = 0;
    tx = '{1, 1, 1}; ty = '{1, 1, 1};
    start_tri(tx, ty);
    finish_tri("single", 1'b1, 0, 1'b0, n);
    chk("single_cycles", 64'(n), ZB ? 64'd5 : 64'd4);
    chk("single_count", 64'(got_q.size()), ZB ? 64'd0 : 64'd1);

    // Vertex at the top of the 16-bit range, random backpressure
    mode = 1; seed = 32'd3; rnd_ready = 1'b1;
    tx = '{630, 65535, 635}; ty = '{0, 2, 1};
    start_tri(tx, ty);
    finish_tri("wide", 1'b0, 0, 1'b0, n);
    rnd_ready = 1'b0;

    // Abort mid-scan, then a fresh triangle
    mode = 0;
    tx = '{0, 3, 0}; ty = '{0, 0, 3};
    start_tri(tx, ty);
    repeat (8) @(negedge clk);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("abort");
    @(negedge clk);
    chk("abort_no_done", {tri_done, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_release", {bus.tri_ready, busy, tri_done}, {1'b1, 1'b0, 1'b0});
    mode = 1; seed = 32'd11;
    tx = '{10, 14, 12}; ty = '{20, 22, 25};
    start_tri(tx, ty);
    finish_tri("after_abort", 1'b1, 0, 1'b0, n);

    // Randomised triangles against the model
    rnd_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      seed = $urandom;
      bx = $urandom_range(0, 660);
      by = $urandom_range(0, 495);
      for (int i = 0; i < 3; i++) begin
        tx[i] = bx + $urandom_range(0, 7);
        ty[i] = by + $urandom_range(0, 7);
      end
      start_tri(tx, ty);
      finish_tri($sformatf("rnd%0d", t), 1'b0, 0, 1'b0, n);
    end
    rnd_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
